pipe_ctrl: RTL and testbench

//  Pipeline control unit for the 5-stage y86 core. Computes per-cycle stall/bubble controls for the
//  F, D, E, M and W pipeline registers: load/use, ret, mispredicted jXX and exception handling.

---
 rtl/pipe_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline control unit for the 5-stage y86 core. Produces the
//            per-cycle stall/bubble controls for the F/D/E/M/W pipeline
//            registers (load/use, ret, mispredicted jXX, exceptions). It also
//            runs a post-reset flush of the unreset pipeline registers and
//            freezes the pipe once W_stat leaves AOK.
//            Optional feature macro: PIPE_PERF_EN (adds perf_* counters).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 5,
    parameter int PERF_W       = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_dstM,
    input  logic              e_Cnd,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        m_stat,
    input  logic [3:0]        W_stat,
    output logic              F_stall,
    output logic              D_stall,
    output logic              D_bubble,
    output logic              E_bubble,
    output logic              M_bubble,
    output logic              W_stall,
    output logic              set_cc,
    output logic [3:0]        cpu_stat,
    output logic              halted
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_lu,
    output logic [PERF_W-1:0] perf_mis,
    output logic [PERF_W-1:0] perf_ret
`endif
);

    // Status encoding
    localparam logic [3:0] c_STAT_AOK = 4'b1000;

    // Instruction codes that matter to hazard detection
    localparam logic [3:0] c_I_OP     = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_POPQ   = 4'hB;
    localparam logic [3:0] c_REG_NONE = 4'hF;

    // Controller states
    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    // Last flush count value before entering RUN
    localparam logic [3:0] c_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    // Reject out-of-range configurations at elaboration time
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || PERF_W < 1) begin : g_param_check
        $error("pipe_ctrl: FLUSH_CYCLES must be 1..15 and PERF_W >= 1");
    end

    logic [1:0] r_state;
    logic [3:0] r_flush_cnt;
    logic [3:0] r_cpu_stat;
    logic       r_halted;

    logic w_lu;
    logic w_ret;
    logic w_mis;
    logic w_exc_m;
    logic w_exc_w;
    logic w_run;

    // Hazard decode from the current pipeline register contents
    always_comb begin
        w_lu    = ((E_icode == c_I_MRMOVQ) || (E_icode == c_I_POPQ)) &&
                  (E_dstM != c_REG_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        w_ret   = (D_icode == c_I_RET) || (E_icode == c_I_RET) || (M_icode == c_I_RET);
        w_mis   = (E_icode == c_I_JXX) && !e_Cnd;
        w_exc_m = (m_stat != c_STAT_AOK);
        w_exc_w = (W_stat != c_STAT_AOK);
        w_run   = (r_state == c_ST_RUN);
    end

    // Controller FSM: flush after reset, run, then freeze on a W-stage exception
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= c_ST_INIT;
            r_flush_cnt <= 4'd0;
            r_cpu_stat  <= c_STAT_AOK;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    r_flush_cnt <= r_flush_cnt + 4'd1;
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_exc_w) begin
                        r_state    <= c_ST_HALT;
                        r_cpu_stat <= W_stat;
                        r_halted   <= 1'b1;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state     <= c_ST_INIT;
                    r_flush_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Stage controls; inputs only influence them while running so the
    // flush and frozen phases are X-free regardless of pipeline contents
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                // lu + ret together: stall F/D and bubble E, the ret bubble
                // in D is suppressed because D is being held
                F_stall  = w_lu | w_ret;
                D_stall  = w_lu;
                D_bubble = w_mis | (!w_lu & w_ret);
                E_bubble = w_mis | w_lu;
                M_bubble = w_exc_m | w_exc_w;
                W_stall  = w_exc_w;
                set_cc   = (E_icode == c_I_OP) & !w_exc_m & !w_exc_w;
            end
            c_ST_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b0;
                M_bubble = 1'b0;
                W_stall  = 1'b1;
                set_cc   = 1'b0;
            end
            default: begin
                F_stall  = 1'b1;
                D_stall  = 1'b0;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b0;
                set_cc   = 1'b0;
            end
        endcase
    end

    assign cpu_stat = r_cpu_stat;
    assign halted   = r_halted;

`ifdef PIPE_PERF_EN
    logic [PERF_W-1:0] r_perf_cycles;
    logic [PERF_W-1:0] r_perf_lu;
    logic [PERF_W-1:0] r_perf_mis;
    logic [PERF_W-1:0] r_perf_ret;

    // Event counters, active only while running so they freeze in HALT
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perf_cycles <= '0;
            r_perf_lu     <= '0;
            r_perf_mis    <= '0;
            r_perf_ret    <= '0;
        end else if (w_run) begin
            r_perf_cycles <= r_perf_cycles + 1'b1;
            if (w_lu) begin
                r_perf_lu <= r_perf_lu + 1'b1;
            end
            if (w_mis) begin
                r_perf_mis <= r_perf_mis + 1'b1;
            end
            if (w_ret) begin
                r_perf_ret <= r_perf_ret + 1'b1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_lu     = r_perf_lu;
    assign perf_mis    = r_perf_mis;
    assign perf_ret    = r_perf_ret;
`else
    // Run decode only feeds the counters; keep it referenced
    logic w_unused_run;
    assign w_unused_run = w_run;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Self-checking bench for pipe_ctrl. Expected control vectors are
//            queued as each step is driven and compared at the next negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic       clock;
    logic       reset_n;
    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [3:0] m_stat;
    logic [3:0] W_stat;
    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_stall;
    logic       set_cc;
    logic [3:0] cpu_stat;
    logic       halted;
`ifdef PIPE_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_lu;
    logic [31:0] perf_mis;
    logic [31:0] perf_ret;
`endif

    int total;
    int bad;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    // Control vectors {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
    localparam logic [6:0] CTL_IDLE  = 7'b0000000;
    localparam logic [6:0] CTL_INIT  = 7'b1011100;
    localparam logic [6:0] CTL_LU    = 7'b1101000;
    localparam logic [6:0] CTL_RET   = 7'b1010000;
    localparam logic [6:0] CTL_MIS   = 7'b0011000;
    localparam logic [6:0] CTL_CC    = 7'b0000001;
    localparam logic [6:0] CTL_EXCM  = 7'b0000100;
    localparam logic [6:0] CTL_EXCW  = 7'b0000110;
    localparam logic [11:0] EXP_HALT = {7'b1100010, 4'b0010, 1'b1};

    pipe_ctrl dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .M_icode  (M_icode),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .E_bubble (E_bubble),
        .M_bubble (M_bubble),
        .W_stall  (W_stall),
        .set_cc   (set_cc),
        .cpu_stat (cpu_stat),
        .halted   (halted)
`ifdef PIPE_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_lu     (perf_lu),
        .perf_mis    (perf_mis),
        .perf_ret    (perf_ret)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [11:0] run_exp(input logic [6:0] ctl);
        return {ctl, 4'b1000, 1'b0};
    endfunction

    task automatic set_idle();
        D_icode = 4'h1;
        d_srcA  = 4'hF;
        d_srcB  = 4'hF;
        E_icode = 4'h1;
        E_dstM  = 4'hF;
        e_Cnd   = 1'b1;
        M_icode = 4'h1;
        m_stat  = 4'b1000;
        W_stat  = 4'b1000;
    endtask

    // Queue the expectation for the inputs just driven, compare at negedge,
    // then advance to just after the next rising edge
    task automatic chk(input string tag, input logic [11:0] expv);
        logic [11:0] obs;
        logic [11:0] want;
        string       t;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(negedge clock);
        obs  = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, cpu_stat, halted};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", t, obs, want);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        set_idle();
        reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Flush: exactly five bubble cycles, then RUN
        for (int i = 0; i < 5; i++) chk("init_flush", run_exp(CTL_INIT));
        chk("run_idle", run_exp(CTL_IDLE));

        // Load/use via srcA, then no sources, then popq via srcB
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        chk("lu_mrmov_srcA", run_exp(CTL_LU));
        d_srcA = 4'hF; d_srcB = 4'hF;
        chk("lu_no_src", run_exp(CTL_IDLE));
        E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
        chk("lu_popq_srcB", run_exp(CTL_LU));
        set_idle();

        // Mispredicted and correctly predicted jXX
        E_icode = 4'h7; e_Cnd = 1'b0;
        chk("jxx_mis", run_exp(CTL_MIS));
        e_Cnd = 1'b1;
        chk("jxx_taken", run_exp(CTL_IDLE));
        set_idle();

        // ret walking through D, E, M
        D_icode = 4'h9;
        chk("ret_D", run_exp(CTL_RET));
        D_icode = 4'h1; E_icode = 4'h9;
        chk("ret_E", run_exp(CTL_RET));
        E_icode = 4'h1; M_icode = 4'h9;
        chk("ret_M", run_exp(CTL_RET));
        set_idle();

        // ret in D together with load/use
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        chk("ret_plus_lu", run_exp(CTL_LU));
        set_idle();

        // CC update, suppressed by M exception, then W exception freezes
        E_icode = 4'h6;
        chk("set_cc", run_exp(CTL_CC));
        m_stat = 4'b0010;
        chk("exc_m", run_exp(CTL_EXCM));
        E_icode = 4'h1; m_stat = 4'b1000; W_stat = 4'b0010;
        chk("exc_w", run_exp(CTL_EXCW));

        // HALT held for 100 cycles regardless of inputs
        for (int i = 0; i < 100; i++) begin
            D_icode = 4'($urandom); d_srcA = 4'($urandom); d_srcB = 4'($urandom);
            E_icode = 4'($urandom); E_dstM = 4'($urandom); e_Cnd = 1'($urandom);
            M_icode = 4'($urandom); m_stat = 4'($urandom); W_stat = 4'($urandom);
            chk("halt_hold", EXP_HALT);
        end

        // Reset out of HALT: flush again, then 10 RUN cycles with 2 load/use
        set_idle();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) chk("reinit_flush", run_exp(CTL_INIT));
        for (int i = 0; i < 10; i++) begin
            set_idle();
            if (i == 2 || i == 7) begin
                E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2;
                chk("rerun_lu", run_exp(CTL_LU));
            end else begin
                chk("rerun_idle", run_exp(CTL_IDLE));
            end
        end
`ifdef PIPE_PERF_EN
        chk32("perf_cycles", perf_cycles, 32'd10);
        chk32("perf_lu", perf_lu, 32'd2);
        chk32("perf_mis", perf_mis, 32'd0);
        chk32("perf_ret", perf_ret, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
